// File: rtl/rom_access_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port instruction ROM.
// m0 is the read-only fetch port, m1 the loader/debug port with gated writes.
module rom_access_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              wr_enable,
  input  logic              stall,
  input  logic              clr_err,
  output logic              wr_err,
  output logic [CNT_W-1:0]  m0_count,
  output logic [CNT_W-1:0]  m1_count,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic              rom_debugaccess,
  output logic              rom_clken,
  output logic              rom_reset_req,
  output logic [DATA_W-1:0] rom_writedata,
  output logic [BE_W-1:0]   rom_byteenable,
  input  logic [DATA_W-1:0] rom_readdata
);

  logic             req0, req1;
  logic             grant0, grant1;
  logic             wr_commit, wr_locked;
  logic             last1_q, last1_d;
  logic             pend0_q, pend0_d;
  logic             pend1_q, pend1_d;
  logic             wr_err_q, wr_err_d;
  logic [CNT_W-1:0] m0_count_q, m0_count_d;
  logic [CNT_W-1:0] m1_count_q, m1_count_d;

  always_comb begin
    req0 = m0_read;
    req1 = m1_read | m1_write;
    // last1_q set means m1 was granted last, so m0 wins a tie
    grant0 = reset_n & ~stall & req0 & (~req1 | last1_q);
    grant1 = reset_n & ~stall & req1 & (~req0 | ~last1_q);
    wr_commit = grant1 & m1_write & wr_enable;
    wr_locked = grant1 & m1_write & ~wr_enable;
  end

  always_comb begin
    m0_waitrequest   = ~grant0;
    m1_waitrequest   = ~grant1;
    rom_address      = grant1 ? m1_address : m0_address;
    rom_writedata    = grant1 ? m1_writedata : '0;
    rom_byteenable   = grant1 ? m1_byteenable : '1;
    rom_chipselect   = (grant0 | grant1) & ~wr_locked;
    rom_write        = wr_commit;
    rom_debugaccess  = wr_commit;
    rom_clken        = ~stall;
    rom_reset_req    = 1'b0;
    m0_readdata      = rom_readdata;
    m1_readdata      = rom_readdata;
    m0_readdatavalid = pend0_q & ~stall;
    m1_readdatavalid = pend1_q & ~stall;
    wr_err           = wr_err_q;
    m0_count         = m0_count_q;
    m1_count         = m1_count_q;
  end

  always_comb begin
    last1_d = last1_q;
    if (grant0)      last1_d = 1'b0;
    else if (grant1) last1_d = 1'b1;

    // grants imply stall=0, so pending reads naturally freeze during a stall
    pend0_d = stall ? pend0_q : grant0;
    pend1_d = stall ? pend1_q : (grant1 & ~m1_write);

    wr_err_d = wr_err_q;
    if (wr_locked)    wr_err_d = 1'b1;
    else if (clr_err) wr_err_d = 1'b0;

    m0_count_d = m0_count_q;
    if (grant0 && (m0_count_q != '1)) m0_count_d = m0_count_q + CNT_W'(1);
    m1_count_d = m1_count_q;
    if (grant1 && (m1_count_q != '1)) m1_count_d = m1_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last1_q    <= 1'b1;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      m0_count_q <= '0;
      m1_count_q <= '0;
    end else begin
      last1_q    <= last1_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      wr_err_q   <= wr_err_d;
      m0_count_q <= m0_count_d;
      m1_count_q <= m1_count_d;
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboarded bench for rom_access_arbiter with a behavioural ROM attached.
module tb_rom_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  m0_address = '0;
  logic        m0_read = 1'b0;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic [9:0]  m1_address = '0;
  logic        m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_writedata = '0;
  logic [3:0]  m1_byteenable = '0;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic        wr_enable = 1'b0, stall = 1'b0, clr_err = 1'b0;
  logic        wr_err;
  logic [15:0] m0_count, m1_count;
  logic [9:0]  rom_address;
  logic        rom_chipselect, rom_write, rom_debugaccess, rom_clken, rom_reset_req;
  logic [31:0] rom_writedata;
  logic [3:0]  rom_byteenable;
  logic [31:0] rom_readdata;

  // second instance with narrow counters for saturation
  logic        s_m0_read = 1'b0;
  logic        s_m0_wr, s_m0_rdv, s_m1_wr, s_m1_rdv, s_wr_err;
  logic [31:0] s_m0_rd, s_m1_rd, s_rom_wd;
  logic [3:0]  s_m0_count, s_m1_count, s_rom_be;
  logic [9:0]  s_rom_addr;
  logic        s_cs, s_we, s_dbg, s_clken, s_rreq;
  logic [9:0]  s_zero_addr = '0;
  logic [31:0] s_zero_data = '0;
  logic [3:0]  s_zero_be = '0;
  logic        s_zero = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] rom_mem [1024];
  logic [31:0] shadow  [1024];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  rom_access_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .wr_enable(wr_enable), .stall(stall), .clr_err(clr_err), .wr_err(wr_err),
    .m0_count(m0_count), .m1_count(m1_count),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_write(rom_write),
    .rom_debugaccess(rom_debugaccess), .rom_clken(rom_clken), .rom_reset_req(rom_reset_req),
    .rom_writedata(rom_writedata), .rom_byteenable(rom_byteenable),
    .rom_readdata(rom_readdata)
  );

  rom_access_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .m0_address(s_zero_addr), .m0_read(s_m0_read), .m0_waitrequest(s_m0_wr),
    .m0_readdata(s_m0_rd), .m0_readdatavalid(s_m0_rdv),
    .m1_address(s_zero_addr), .m1_read(s_zero), .m1_write(s_zero),
    .m1_writedata(s_zero_data), .m1_byteenable(s_zero_be),
    .m1_waitrequest(s_m1_wr), .m1_readdata(s_m1_rd), .m1_readdatavalid(s_m1_rdv),
    .wr_enable(s_zero), .stall(s_zero), .clr_err(s_zero), .wr_err(s_wr_err),
    .m0_count(s_m0_count), .m1_count(s_m1_count),
    .rom_address(s_rom_addr), .rom_chipselect(s_cs), .rom_write(s_we),
    .rom_debugaccess(s_dbg), .rom_clken(s_clken), .rom_reset_req(s_rreq),
    .rom_writedata(s_rom_wd), .rom_byteenable(s_rom_be), .rom_readdata(s_zero_data)
  );

  always #5 clk = ~clk;

  // Behavioural ROM: address registered on every enabled edge, byte-lane writes
  always @(posedge clk) begin
    if (rom_clken) begin
      if (rom_chipselect && rom_write)
        for (int b = 0; b < 4; b++)
          if (rom_byteenable[b]) rom_mem[rom_address][b*8 +: 8] <= rom_writedata[b*8 +: 8];
      rom_readdata <= rom_mem[rom_address];
    end
  end

  // Scoreboard: expected data pushed at acceptance, popped when readdatavalid shows
  always @(negedge clk) begin
    logic [31:0] e;
    if (m0_readdatavalid) begin
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL m0_unexpected_rdv: got valid=1 data=%h expected no return", m0_readdata);
      end else begin
        e = q0.pop_front();
        if (m0_readdata !== e) begin
          miscompares++;
          $display("FAIL m0_readdata: got %h expected %h", m0_readdata, e);
        end
      end
    end
    if (m1_readdatavalid) begin
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL m1_unexpected_rdv: got valid=1 data=%h expected no return", m1_readdata);
      end else begin
        e = q1.pop_front();
        if (m1_readdata !== e) begin
          miscompares++;
          $display("FAIL m1_readdata: got %h expected %h", m1_readdata, e);
        end
      end
    end
    if (reset_n) begin
      if (m0_read && !m0_waitrequest) q0.push_back(shadow[m0_address]);
      if (m1_read && !m1_write && !m1_waitrequest) q1.push_back(shadow[m1_address]);
      if (m1_write && !m1_waitrequest && wr_enable)
        for (int b = 0; b < 4; b++)
          if (m1_byteenable[b]) shadow[m1_address][b*8 +: 8] = m1_writedata[b*8 +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    m0_read = 1'b1;
    m1_read = 1'b1;
    @(negedge clk);
    vectors++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_waitrequest: got %b expected 11", {m0_waitrequest, m1_waitrequest});
    end
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid, wr_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000", {m0_readdatavalid, m1_readdatavalid, wr_err});
    end
    vectors++;
    if ({m0_count, m1_count} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_counts: got %h expected 00000000", {m0_count, m1_count});
    end
    m0_read = 1'b0;
    m1_read = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    m0_address = 10'h005;
    m0_read = 1'b1;
    @(negedge clk);
    vectors++;
    if (m0_waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wait: got %b expected 0", m0_waitrequest);
    end
    step();
    m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL single_return: got valid=%b data=%h expected valid=1 data=00001234",
               m0_readdatavalid, m0_readdata);
    end
    vectors++;
    if (m0_count !== 16'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d expected 1", m0_count);
    end
    step();
  endtask

  task automatic test_round_robin();
    apply_reset();
    m0_read = 1'b1;
    m1_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m0_address = 10'(i);
      m1_address = 10'(10'h100 + i);
      @(negedge clk);
      vectors++;
      if ({m0_waitrequest, m1_waitrequest} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got wait=%b expected %b", i,
                 {m0_waitrequest, m1_waitrequest}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      vectors++;
      if ({m0_readdatavalid, m1_readdatavalid} !==
          ((i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b10 : 2'b01))) begin
        miscompares++;
        $display("FAIL rr_valid[%0d]: got %b", i, {m0_readdatavalid, m1_readdatavalid});
      end
      step();
    end
    m0_read = 1'b0;
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_last_valid: got %b expected 01", {m0_readdatavalid, m1_readdatavalid});
    end
    vectors++;
    if (m0_count !== 16'd3 || m1_count !== 16'd3) begin
      miscompares++;
      $display("FAIL rr_counts: got %0d/%0d expected 3/3", m0_count, m1_count);
    end
    step();
  endtask

  task automatic test_write();
    wr_enable = 1'b1;
    m1_address = 10'h010;
    m1_writedata = 32'hDEAD_BEEF;
    m1_byteenable = 4'hF;
    m1_write = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rom_write, rom_debugaccess, rom_chipselect, m1_waitrequest} !== 4'b1110) begin
      miscompares++;
      $display("FAIL write_ctrl: got %b expected 1110",
               {rom_write, rom_debugaccess, rom_chipselect, m1_waitrequest});
    end
    step();
    m1_write = 1'b0;
    m0_address = 10'h010;
    m0_read = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rom_write, rom_debugaccess, m1_readdatavalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_once: got %b expected 000", {rom_write, rom_debugaccess, m1_readdatavalid});
    end
    step();
    m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_readback: got valid=%b data=%h expected valid=1 data=deadbeef",
               m0_readdatavalid, m0_readdata);
    end
    step();
  endtask

  task automatic test_locked_write();
    wr_enable = 1'b0;
    m1_address = 10'h3FF;
    m1_writedata = 32'h1111_2222;
    m1_write = 1'b1;
    @(negedge clk);
    vectors++;
    if ({m1_waitrequest, rom_write, rom_chipselect, wr_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL locked_ctrl: got %b expected 0000",
               {m1_waitrequest, rom_write, rom_chipselect, wr_err});
    end
    step();
    m1_write = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b1 || m1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL locked_err_set: got err=%b rdv=%b expected err=1 rdv=0", wr_err, m1_readdatavalid);
    end
    step();
    step();
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL locked_err_sticky: got %b expected 1", wr_err);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL locked_err_clear: got %b expected 0", wr_err);
    end
    step();
    clr_err = 1'b1;
    m1_write = 1'b1;
    step();
    clr_err = 1'b0;
    m1_write = 1'b0;
    m1_read = 1'b1;
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL locked_set_wins: got %b expected 1", wr_err);
    end
    step();
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hC0DE_03FF) begin
      miscompares++;
      $display("FAIL locked_untouched: got valid=%b data=%h expected valid=1 data=c0de03ff",
               m1_readdatavalid, m1_readdata);
    end
    vectors++;
    if (m1_count !== 16'd7) begin
      miscompares++;
      $display("FAIL locked_count: got %0d expected 7", m1_count);
    end
    step();
  endtask

  task automatic test_stall();
    logic [15:0] c0, c1;
    m0_address = 10'h007;
    m0_read = 1'b1;
    step();
    c0 = m0_count;
    c1 = m1_count;
    stall = 1'b1;
    m0_address = 10'h008;
    m1_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({m0_readdatavalid, m0_waitrequest, m1_waitrequest, rom_clken} !== 4'b0110) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %b expected 0110", i,
                 {m0_readdatavalid, m0_waitrequest, m1_waitrequest, rom_clken});
      end
      step();
    end
    stall = 1'b0;
    m0_read = 1'b0;
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hC0DE_0007) begin
      miscompares++;
      $display("FAIL stall_release: got valid=%b data=%h expected valid=1 data=c0de0007",
               m0_readdatavalid, m0_readdata);
    end
    vectors++;
    if (m0_count !== c0 || m1_count !== c1) begin
      miscompares++;
      $display("FAIL stall_counts: got %0d/%0d expected %0d/%0d", m0_count, m1_count, c0, c1);
    end
    step();
  endtask

  task automatic test_reset_mid();
    m0_address = 10'h009;
    m0_read = 1'b1;
    step();
    m0_read = 1'b0;
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_mid_valid[%0d]: got %b expected 00", i, {m0_readdatavalid, m1_readdatavalid});
      end
      step();
    end
    vectors++;
    if ({m0_count, m1_count} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_counts: got %h expected 00000000", {m0_count, m1_count});
    end
  endtask

  task automatic test_saturate();
    s_m0_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) begin
        vectors++;
        if (s_m0_count !== 4'd14) begin
          miscompares++;
          $display("FAIL sat_mid: got %0d expected 14", s_m0_count);
        end
      end
    end
    s_m0_read = 1'b0;
    vectors++;
    if (s_m0_count !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_final: got %0d expected 15", s_m0_count);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      rom_mem[a] = 32'hC0DE_0000 | 32'(a);
      shadow[a]  = 32'hC0DE_0000 | 32'(a);
    end
    rom_mem[5] = 32'h0000_1234;
    shadow[5]  = 32'h0000_1234;
    step();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_locked_write();
    test_stall();
    test_reset_mid();
    test_saturate();
    step();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL outstanding_reads: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Two-port arbiter and sequencer for the 1024×32 single-port on-chip instruction ROM: it shares the memory between the processor fetch path (port m0, read-only) and a program loader/debug path (port m1, read/write). It drives the ROM's chipselect/write/debugaccess/clken controls and returns read data with a per-port readdatavalid. Round-robin arbitration runs at one access per cycle. Loader writes are gated by a write-unlock input and reported through a sticky error flag.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- CNT_W, 16, width of per-port accepted-transaction counters

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- m0_address  in  ADDR_W  fetch word address
- m0_read  in  1  fetch read request
- m0_waitrequest  out  1  high = m0 request not accepted this cycle
- m0_readdata  out  DATA_W  read data for m0
- m0_readdatavalid  out  1  m0_readdata valid this cycle
- m1_address  in  ADDR_W  loader word address
- m1_read, m1_write  in  1 each  loader read / write request
- m1_writedata  in  DATA_W  loader write data
- m1_byteenable  in  BE_W  loader byte lanes
- m1_waitrequest  out  1  high = m1 request not accepted
- m1_readdata  out  DATA_W  read data for m1
- m1_readdatavalid  out  1  m1_readdata valid this cycle
- wr_enable  in  1  write unlock; writes are dropped while low
- stall  in  1  global hold; no grants issued and the ROM clock enable is deasserted
- clr_err  in  1  clears wr_err
- wr_err  out  1  sticky flag: a write was attempted while wr_enable was low
- m0_count, m1_count  out  CNT_W each  saturating counts of accepted transactions
- rom_address  out  ADDR_W; rom_chipselect, rom_write, rom_debugaccess, rom_clken, rom_reset_req  out  1 each; rom_writedata  out  DATA_W; rom_byteenable  out  BE_W
- rom_readdata  in  DATA_W  ROM output; valid one cycle after its address is captured

## Operation
- Requests: req0 = m0_read; req1 = m1_read | m1_write. If m1_read and m1_write are both high, the access is treated as a write.
- Grant is combinational, at most one per cycle, and none while stall=1:
  - only one port requesting → that port is granted;
  - both requesting → the port that was NOT last granted wins.
  - last_grant updates on every grant.
- mX_waitrequest = ~grantX. Both are forced to 1 while reset_n=0. A transaction is accepted in the cycle where request is high and waitrequest is low.
- ROM drive:
  - rom_address, rom_writedata and rom_byteenable are muxed from the granted port.
  - m0 reads use byteenable all ones.
  - With no grant, the outputs hold the m0 values.
  - rom_chipselect = grant & ~(m1 write with wr_enable=0).
  - rom_write = rom_debugaccess = grant1 & m1_write & wr_enable.
  - rom_clken = ~stall; rom_reset_req = 0.
- Read return: pendX <= (accepted read of port X) on edges where stall=0; pendX holds while stall=1.
  - mX_readdatavalid = pendX & ~stall.
  - mX_readdata = rom_readdata on both ports.
- Writes never produce readdatavalid.
- Locked write (m1_write accepted while wr_enable=0):
  - the request is accepted with waitrequest low, and no ROM access occurs;
  - wr_err is set at the next edge.
  - If clr_err and a set occur in the same cycle, the set wins.
- Counters increment by 1 per accepted transaction (dropped writes included) and saturate at 2^CNT_W−1. Only reset clears them.

## Timing
- Reset values: wr_err=0, m0_count=m1_count=0, pend0=pend1=0, readdatavalid=0, waitrequest=1, last_grant=m1 (so m0 wins the first tie).
- Read latency: accept at edge N → readdatavalid and data in cycle N+1, provided stall=0 in cycle N+1. Otherwise data is returned in the first cycle with stall=0; the ROM address register is frozen, so the data is held.
- Throughput is one access per cycle. Back-to-back reads from alternating ports are fully pipelined.
- Write commit: at the accept edge.
- A read from either port accepted in the cycle after a write to the same address returns the new data.
- Reset asserted mid-transaction: pending reads are discarded and no readdatavalid appears after release.
- stall asserted in the same cycle as requests: no grant, waitrequest=1 for the requesting ports, counters unchanged.

## Test plan
- After reset release, m0 reads address 0x005 with ROM word 0x0000_1234 → m0_waitrequest=0 in the same cycle; m0_readdatavalid=1 with 0x0000_1234 one cycle later; m0_count=1.
- m0 and m1 both read continuously for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid follows its grant by one cycle; both counts = 3.
- wr_enable=1, m1 writes 0xDEAD_BEEF with byteenable 0xF to 0x010, then m0 reads 0x010 → rom_write=rom_debugaccess=1 for one cycle; m0 receives 0xDEAD_BEEF.
- wr_enable=0, m1 writes 0x3FF → rom_write=0, rom_chipselect=0, wr_err=1 at the next edge and staying 1; clr_err pulse → wr_err=0; clr_err in the same cycle as a new locked write → wr_err stays 1.
- m0 read accepted, then stall=1 for 3 cycles → no readdatavalid during the stall; data valid in the first cycle after stall drops; requests during the stall see waitrequest=1.
- reset_n pulsed low the cycle after a read is accepted → no readdatavalid, counters=0; CNT_W=4 with 20 m0 reads → m0_count saturates at 15.
